// File: rtl/wb_burst_ram_slave.sv
// wb_burst_ram_slave
// Wishbone B4 slave with registered-feedback bursts over a single-port RAM.
// An internal address counter prefetches the next burst word so that
// incrementing and wrapping bursts run at one beat per cycle after a single
// wait state.
//
// Optional feature macro: WB_BURST_RAM_BURST_EN
//   defined   : CTI/BTE decoded, bursts supported, reserved CTI -> sa_err_o
//   undefined : CTI/BTE ignored, every request is a classic cycle, no error
//
// Ports:
//   clk        clock, rising edge
//   reset      asynchronous active-low reset
//   sa_adr_i   word address           sa_dat_i  write data
//   sa_sel_i   byte enables           sa_tag_i  tag (ignored)
//   sa_cti_i   cycle type             sa_bte_i  burst type
//   sa_we_i    write enable           sa_cyc_i  bus cycle
//   sa_stb_i   strobe
//   sa_dat_o   registered read data   sa_ack_o  registered acknowledge
//   sa_err_o   registered error       sa_rty_o  retry (always 0)
module wb_burst_ram_slave #(
  parameter int Dw   = 32,
  parameter int Aw   = 10,
  parameter int SELw = Dw / 8,
  parameter int TAGw = 3,
  parameter int CTIw = 3,
  parameter int BTEw = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [Aw-1:0]   sa_adr_i,
  input  logic [Dw-1:0]   sa_dat_i,
  input  logic [SELw-1:0] sa_sel_i,
  input  logic [TAGw-1:0] sa_tag_i,
  input  logic [CTIw-1:0] sa_cti_i,
  input  logic [BTEw-1:0] sa_bte_i,
  input  logic            sa_we_i,
  input  logic            sa_cyc_i,
  input  logic            sa_stb_i,
  output logic [Dw-1:0]   sa_dat_o,
  output logic            sa_ack_o,
  output logic            sa_err_o,
  output logic            sa_rty_o
);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [Aw-1:0]   cur_adr_q, cur_adr_d;
  logic [Dw-1:0]   dat_q, dat_d;
  logic            ack_q, ack_d;
  logic            err_q, err_d;

  logic [Dw-1:0]   mem [2**Aw];

  logic            valid;
  logic            cti_ok;    // classic / incrementing / end-of-burst
  logic            cti_incr;  // burst continues after this beat
  logic [Aw-1:0]   nxt_adr;
  logic [Aw-1:0]   rd_adr;
  logic            mem_we;

  assign valid = sa_stb_i & sa_cyc_i;

`ifdef WB_BURST_RAM_BURST_EN
  logic unused_inputs;
  assign unused_inputs = ^sa_tag_i;

  always_comb begin
    cti_ok = 1'b0;
    case (sa_cti_i)
      CTIw'(3'b000), CTIw'(3'b010), CTIw'(3'b111): cti_ok = 1'b1;
      default:                                     cti_ok = 1'b0;
    endcase
  end

  assign cti_incr = (sa_cti_i == CTIw'(3'b010));

  // Wrapping bursts only advance the low address bits; the upper bits stay.
  always_comb begin
    nxt_adr = cur_adr_q + Aw'(1);
    case (sa_bte_i)
      BTEw'(2'b01): nxt_adr = {cur_adr_q[Aw-1:2], cur_adr_q[1:0] + 2'd1};
      BTEw'(2'b10): nxt_adr = {cur_adr_q[Aw-1:3], cur_adr_q[2:0] + 3'd1};
      BTEw'(2'b11): nxt_adr = {cur_adr_q[Aw-1:4], cur_adr_q[3:0] + 4'd1};
      default:      nxt_adr = cur_adr_q + Aw'(1);
    endcase
  end
`else
  logic unused_inputs;
  assign unused_inputs = ^{sa_tag_i, sa_cti_i, sa_bte_i};

  // Every request is classic: the continue path is constant-false, so the
  // address counter only ever loads from sa_adr_i.
  assign cti_ok   = 1'b1;
  assign cti_incr = 1'b0;
  assign nxt_adr  = cur_adr_q;
`endif

  // State and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cur_adr_q <= '0;
      dat_q     <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_adr_q <= cur_adr_d;
      dat_q     <= dat_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (valid && !ack_q && !err_q && cti_ok) state_d = ST_ACTIVE;
      ST_ACTIVE: if (!(valid && cti_incr))                state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output / datapath logic. One RAM read port: in IDLE it looks up the
  // requested address, in ACTIVE it prefetches the next burst word.
  always_comb begin
    ack_d     = 1'b0;
    err_d     = 1'b0;
    dat_d     = dat_q;
    cur_adr_d = cur_adr_q;
    mem_we    = 1'b0;
    rd_adr    = (state_q == ST_ACTIVE) ? nxt_adr : sa_adr_i;
    case (state_q)
      ST_IDLE: begin
        if (valid && !ack_q && !err_q) begin
          cur_adr_d = sa_adr_i;
          if (!sa_we_i) dat_d = mem[rd_adr];
          if (cti_ok) ack_d = 1'b1;
          else        err_d = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (valid) begin
          mem_we = sa_we_i;
          if (cti_incr) begin
            cur_adr_d = nxt_adr;
            dat_d     = mem[rd_adr];
            ack_d     = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // RAM write port; contents are not affected by reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned i = 0; i < SELw; i++) begin
        if (sa_sel_i[i]) mem[cur_adr_q][i*8 +: 8] <= sa_dat_i[i*8 +: 8];
      end
    end
  end

  assign sa_dat_o = dat_q;
  assign sa_ack_o = ack_q;
  assign sa_err_o = err_q;
  assign sa_rty_o = 1'b0;

endmodule

// File: tb/tb_wb_burst_ram_slave.sv
// Directed testbench for wb_burst_ram_slave (Dw=32, Aw=10).
// Burst-specific steps are compiled only when WB_BURST_RAM_BURST_EN is
// defined; otherwise the classic-only behaviour of CTI/BTE is exercised.
module tb_wb_burst_ram_slave;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  sa_adr_i;
  logic [31:0] sa_dat_i;
  logic [3:0]  sa_sel_i;
  logic [2:0]  sa_tag_i;
  logic [2:0]  sa_cti_i;
  logic [1:0]  sa_bte_i;
  logic        sa_we_i;
  logic        sa_cyc_i;
  logic        sa_stb_i;
  logic [31:0] sa_dat_o;
  logic        sa_ack_o;
  logic        sa_err_o;
  logic        sa_rty_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wb_burst_ram_slave #(
    .Dw(32), .Aw(10), .SELw(4), .TAGw(3), .CTIw(3), .BTEw(2)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .sa_adr_i(sa_adr_i),
    .sa_dat_i(sa_dat_i),
    .sa_sel_i(sa_sel_i),
    .sa_tag_i(sa_tag_i),
    .sa_cti_i(sa_cti_i),
    .sa_bte_i(sa_bte_i),
    .sa_we_i (sa_we_i),
    .sa_cyc_i(sa_cyc_i),
    .sa_stb_i(sa_stb_i),
    .sa_dat_o(sa_dat_o),
    .sa_ack_o(sa_ack_o),
    .sa_err_o(sa_err_o),
    .sa_rty_o(sa_rty_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    sa_stb_i = 1'b0;
    sa_cyc_i = 1'b0;
    sa_we_i  = 1'b0;
    sa_cti_i = 3'b000;
    sa_bte_i = 2'b00;
  endtask

  task automatic req(input logic [9:0] adr, input logic we, input logic [31:0] dat,
                     input logic [3:0] sel, input logic [2:0] cti, input logic [1:0] bte);
    sa_adr_i = adr;
    sa_we_i  = we;
    sa_dat_i = dat;
    sa_sel_i = sel;
    sa_cti_i = cti;
    sa_bte_i = bte;
    sa_cyc_i = 1'b1;
    sa_stb_i = 1'b1;
  endtask

  // Classic write: stb held through the acknowledged edge so the write commits.
  task automatic wr(input string tag, input logic [9:0] adr, input logic [31:0] dat,
                    input logic [3:0] sel);
    req(adr, 1'b1, dat, sel, 3'b000, 2'b00);
    tick();
    chk({tag, "_ack"}, 32'(sa_ack_o), 32'd1);
    tick();
    chk({tag, "_ackfall"}, 32'(sa_ack_o), 32'd0);
    bus_idle();
  endtask

  task automatic rd(input string tag, input logic [9:0] adr, input logic [31:0] exp);
    req(adr, 1'b0, 32'h0, 4'h0, 3'b000, 2'b00);
    tick();
    chk({tag, "_ack"}, 32'(sa_ack_o), 32'd1);
    chk({tag, "_dat"}, sa_dat_o, exp);
    bus_idle();
    tick();
    chk({tag, "_ackfall"}, 32'(sa_ack_o), 32'd0);
  endtask

  logic [31:0] wexp [4];

  initial begin
    reset    = 1'b0;
    sa_adr_i = '0;
    sa_dat_i = '0;
    sa_sel_i = '0;
    sa_tag_i = 3'b101;
    bus_idle();
    tick();
    tick();
    chk("rst_ack", 32'(sa_ack_o), 32'd0);
    chk("rst_err", 32'(sa_err_o), 32'd0);
    chk("rst_rty", 32'(sa_rty_o), 32'd0);
    chk("rst_dat", sa_dat_o, 32'h0);
    reset = 1'b1;
    tick();

    // Classic write then read
    wr("wr5", 10'd5, 32'hDEADBEEF, 4'hF);
    rd("rd5", 10'd5, 32'hDEADBEEF);

    // Byte select over an all-ones word
    wr("wr6a", 10'd6, 32'hFFFFFFFF, 4'hF);
    wr("wr6b", 10'd6, 32'h11223344, 4'b0101);
    rd("rd6", 10'd6, 32'hFF22FF44);

    // Preload for the wrap test
    wr("pre8", 10'd8,  32'hAAAA0008, 4'hF);
    wr("pre9", 10'd9,  32'hBBBB0009, 4'hF);
    wr("pre10", 10'd10, 32'hCCCC000A, 4'hF);
    wr("pre11", 10'd11, 32'hDDDD000B, 4'hF);

    // Reset during the acknowledge cycle of a classic write suppresses it
    wr("pre40", 10'd40, 32'h40404040, 4'hF);
    req(10'd40, 1'b1, 32'hBADBAD00, 4'hF, 3'b000, 2'b00);
    tick();
    chk("crst_ack", 32'(sa_ack_o), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("crst_ackasync", 32'(sa_ack_o), 32'd0);
    chk("crst_dat", sa_dat_o, 32'h0);
    bus_idle();
    @(posedge clk);
    #1 reset = 1'b1;
    tick();
    rd("crst_rd40", 10'd40, 32'h40404040);

`ifdef WB_BURST_RAM_BURST_EN
    // Linear burst write across the top of the address space
    req(10'h3FE, 1'b1, 32'd1, 4'hF, 3'b010, 2'b00);
    tick();
    for (int b = 1; b <= 4; b++) begin
      chk($sformatf("lin_ack%0d", b), 32'(sa_ack_o), 32'd1);
      sa_dat_i = b;
      sa_adr_i = 10'h155;
      sa_cti_i = (b == 4) ? 3'b111 : 3'b010;
      tick();
    end
    chk("lin_ackfall", 32'(sa_ack_o), 32'd0);
    bus_idle();
    rd("lin_rd3fe", 10'h3FE, 32'd1);
    rd("lin_rd3ff", 10'h3FF, 32'd2);
    rd("lin_rd000", 10'h000, 32'd3);
    rd("lin_rd001", 10'h001, 32'd4);

    // 4-beat wrap read from address 10
    wexp = '{32'hCCCC000A, 32'hDDDD000B, 32'hAAAA0008, 32'hBBBB0009};
    req(10'd10, 1'b0, 32'h0, 4'h0, 3'b010, 2'b01);
    tick();
    for (int b = 0; b < 4; b++) begin
      chk($sformatf("wrap_ack%0d", b), 32'(sa_ack_o), 32'd1);
      chk($sformatf("wrap_dat%0d", b), sa_dat_o, wexp[b]);
      sa_cti_i = (b == 3) ? 3'b111 : 3'b010;
      tick();
    end
    chk("wrap_ackfall", 32'(sa_ack_o), 32'd0);
    bus_idle();

    // Reserved CTI: one-cycle error, no ack, no write
    req(10'd5, 1'b1, 32'h12345678, 4'hF, 3'b011, 2'b00);
    tick();
    chk("rsv_err", 32'(sa_err_o), 32'd1);
    chk("rsv_ack", 32'(sa_ack_o), 32'd0);
    bus_idle();
    tick();
    chk("rsv_errfall", 32'(sa_err_o), 32'd0);
    rd("rsv_rd5", 10'd5, 32'hDEADBEEF);

    // Strobe dropped mid-burst: ack falls, stalled beat not written
    wr("pre21", 10'd21, 32'h0BAD0BAD, 4'hF);
    req(10'd20, 1'b1, 32'h00000055, 4'hF, 3'b010, 2'b00);
    tick();
    chk("stall_ack1", 32'(sa_ack_o), 32'd1);
    tick();
    chk("stall_ack2", 32'(sa_ack_o), 32'd1);
    sa_stb_i = 1'b0;
    sa_dat_i = 32'h00000066;
    tick();
    chk("stall_ackfall", 32'(sa_ack_o), 32'd0);
    bus_idle();
    rd("stall_rd20", 10'd20, 32'h00000055);
    rd("stall_rd21", 10'd21, 32'h0BAD0BAD);

    // Reset during beat 2 of a write burst
    wr("pre31", 10'd31, 32'hCAFE0031, 4'hF);
    req(10'd30, 1'b1, 32'h00001111, 4'hF, 3'b010, 2'b00);
    tick();
    chk("brst_ack1", 32'(sa_ack_o), 32'd1);
    tick();
    chk("brst_ack2", 32'(sa_ack_o), 32'd1);
    sa_dat_i = 32'h00002222;
    #2 reset = 1'b0;
    #1;
    chk("brst_ackasync", 32'(sa_ack_o), 32'd0);
    chk("brst_err", 32'(sa_err_o), 32'd0);
    bus_idle();
    @(posedge clk);
    #1 reset = 1'b1;
    tick();
    rd("brst_rd30", 10'd30, 32'h00001111);
    rd("brst_rd31", 10'd31, 32'hCAFE0031);
`else
    // Reserved CTI is ignored: classic write with ack and no error
    req(10'd50, 1'b1, 32'h50505050, 4'hF, 3'b011, 2'b00);
    tick();
    chk("cls_rsv_ack", 32'(sa_ack_o), 32'd1);
    chk("cls_rsv_err", 32'(sa_err_o), 32'd0);
    tick();
    chk("cls_rsv_ackfall", 32'(sa_ack_o), 32'd0);
    bus_idle();
    rd("cls_rsv_rd50", 10'd50, 32'h50505050);

    // Incrementing CTI is ignored: a single ack even with stb held
    req(10'd10, 1'b0, 32'h0, 4'h0, 3'b010, 2'b01);
    tick();
    chk("cls_inc_ack", 32'(sa_ack_o), 32'd1);
    chk("cls_inc_dat", sa_dat_o, 32'hCCCC000A);
    tick();
    chk("cls_inc_ackfall", 32'(sa_ack_o), 32'd0);
    chk("cls_inc_datheld", sa_dat_o, 32'hCCCC000A);
    bus_idle();
    tick();
    rd("cls_rd11", 10'd11, 32'hDDDD000B);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
